// File: rtl/conv_mem_loader.sv
// conv_mem_loader
//   Streams an image and a set of filters into the convolution engine's input
//   memory. It then kicks the engine and waits for it to finish.
//
//   Sequence: IDLE -> LOAD_IMG -> (LOAD_FLT) -> START -> WAIT_CONV -> FINISH -> IDLE
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   load_start          begin a load; only honoured in IDLE
//   img_base, flt_base  memory bases, captured when load_start is accepted
//   num_filters         filter count (0..255), captured with the bases
//   in_valid/in_data    incoming word stream
//   in_ready            loader will take a word this cycle
//   mem_wr_en/addr/wdata registered memory write port, one cycle after handshake
//   conv_start          single-cycle engine start
//   conv_done           engine completion; only looked at in WAIT_CONV
//   busy                high whenever not IDLE
//   done                single-cycle completion pulse
module conv_mem_loader #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int IMG_WORDS    = 16,
    parameter int FILTER_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] img_base,
    input  logic [ADDR_W-1:0] flt_base,
    input  logic [7:0]        num_filters,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              conv_start,
    input  logic              conv_done,
    output logic              busy,
    output logic              done
);

    localparam int IMG_CW = $clog2(IMG_WORDS + 1);
    localparam int WRD_CW = $clog2(FILTER_WORDS + 1);
    // Offsets are formed well wider than the address before truncation,
    // so f*FILTER_WORDS+j never overflows ahead of the intended wrap.
    localparam int OFF_W  = ADDR_W + 16;

    typedef enum logic [2:0] {
        IDLE, LOAD_IMG, LOAD_FLT, START, WAIT_CONV, FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] img_base_q, flt_base_q;
    logic [7:0]        nflt_q;
    logic [IMG_CW-1:0] img_cnt;
    logic [WRD_CW-1:0] wrd_cnt;
    logic [7:0]        flt_cnt;

    logic              hs;
    logic [OFF_W-1:0]  img_sum, flt_sum;

    assign hs      = in_valid & in_ready;
    assign img_sum = OFF_W'(img_base_q) + OFF_W'(img_cnt);
    assign flt_sum = OFF_W'(flt_base_q)
                   + OFF_W'(flt_cnt) * OFF_W'(FILTER_WORDS)
                   + OFF_W'(wrd_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            img_base_q <= '0;
            flt_base_q <= '0;
            nflt_q     <= '0;
            img_cnt    <= '0;
            wrd_cnt    <= '0;
            flt_cnt    <= '0;
            in_ready   <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            conv_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // strobes default low; each state raises the one it owns
            mem_wr_en  <= 1'b0;
            conv_start <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (load_start) begin
                        img_base_q <= img_base;
                        flt_base_q <= flt_base;
                        nflt_q     <= num_filters;
                        img_cnt    <= '0;
                        wrd_cnt    <= '0;
                        flt_cnt    <= '0;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LOAD_IMG;
                    end
                end

                LOAD_IMG: begin
                    if (hs) begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= img_sum[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        if (img_cnt == IMG_CW'(IMG_WORDS - 1)) begin
                            img_cnt <= '0;
                            if (nflt_q != 8'd0) begin
                                state <= LOAD_FLT;
                            end else begin
                                // drop ready now so no word beyond the image is taken
                                in_ready <= 1'b0;
                                state    <= START;
                            end
                        end else begin
                            img_cnt <= img_cnt + 1'b1;
                        end
                    end
                end

                LOAD_FLT: begin
                    if (hs) begin
                        mem_wr_en <= 1'b1;
                        mem_addr  <= flt_sum[ADDR_W-1:0];
                        mem_wdata <= in_data;
                        if (wrd_cnt == WRD_CW'(FILTER_WORDS - 1)) begin
                            wrd_cnt <= '0;
                            if (flt_cnt == nflt_q - 8'd1) begin
                                in_ready <= 1'b0;
                                state    <= START;
                            end else begin
                                flt_cnt <= flt_cnt + 8'd1;
                            end
                        end else begin
                            wrd_cnt <= wrd_cnt + 1'b1;
                        end
                    end
                end

                // The last write is on the port during this state, so the
                // start pulse lands one cycle after it has committed.
                START: begin
                    conv_start <= 1'b1;
                    state      <= WAIT_CONV;
                end

                WAIT_CONV: begin
                    if (conv_done) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mem_loader.sv
// Self-checking bench for conv_mem_loader: directed load scenarios with
// randomised data/stalls, compared against an address/data list built from
// the loader's addressing rules.
module tb_conv_mem_loader;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int IW = 16;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [AW-1:0] img_base, flt_base;
    logic [7:0]    num_filters;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          conv_start;
    logic          conv_done;
    logic          busy;
    logic          done;

    conv_mem_loader #(
        .DATA_W(DW), .ADDR_W(AW), .IMG_WORDS(IW), .FILTER_WORDS(FW)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .img_base(img_base), .flt_base(flt_base), .num_filters(num_filters),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .conv_start(conv_start), .conv_done(conv_done),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_hs = -1;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  d;
        logic [31:0] c;
    } wr_t;

    wr_t        wq[$];
    int         csq[$];
    logic [7:0] words[$];

    // cycle N spans posedge N .. posedge N+1; a handshake in cycle N is
    // seen at the edge that closes it
    always @(posedge clk) begin
        if (in_valid && in_ready) last_hs = cyc;
        cyc++;
    end

    always @(negedge clk) begin
        if (mem_wr_en) wq.push_back({mem_addr, mem_wdata, 32'(cyc)});
        if (conv_start) csq.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference addressing: image word k at base+k, filter f word j at
    // fbase + f*FW + j, everything modulo 256.
    function automatic logic [7:0] exp_addr(input int ib, input int fb, input int k);
        int f, j;
        if (k < IW) return 8'((ib + k) % 256);
        f = (k - IW) / FW;
        j = (k - IW) % FW;
        return 8'((fb + f * FW + j) % 256);
    endfunction

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_load(input string nm, input int ib, input int fb, input int nf,
                            input bit seq, input bit stall, input bit inject);
        int total;
        int i;
        int budget;
        int md;
        int n;
        total = IW + FW * nf;
        words.delete();
        for (int k = 0; k < total; k++) words.push_back(seq ? 8'(k + 1) : 8'($urandom));
        wq.delete();
        csq.delete();

        load_start  = 1'b1;
        img_base    = 8'(ib);
        flt_base    = 8'(fb);
        num_filters = 8'(nf);
        @(negedge clk);
        load_start  = 1'b0;
        img_base    = 8'($urandom);   // must already be latched
        flt_base    = 8'($urandom);
        num_filters = 8'($urandom);
        chk({nm, " busy_up"}, 32'(busy), 1);
        chk({nm, " ready_up"}, 32'(in_ready), 1);

        i = 0;
        budget = 0;
        while (i < total && budget < 4000) begin
            in_valid   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data    = words[i];
            load_start = inject && (i == 5);
            conv_done  = inject && (i == IW + 2);
            @(posedge clk);
            if (in_valid && in_ready) i++;
            @(negedge clk);
            budget++;
        end
        in_valid   = 1'b0;
        load_start = 1'b0;
        conv_done  = 1'b0;
        chk({nm, " stream_complete"}, 32'(i), 32'(total));
        chk({nm, " ready_low_after_last"}, 32'(in_ready), 0);
        chk({nm, " last_write_strobe"}, 32'(mem_wr_en), 1);

        md = 0;
        while (csq.size() == 0 && md < 20) begin
            @(negedge clk);
            md++;
        end
        chk({nm, " conv_start_count"}, 32'(csq.size()), 1);
        if (csq.size() > 0) chk({nm, " conv_start_cycle"}, 32'(csq[0]), 32'(last_hs + 2));

        chk({nm, " write_count"}, 32'(wq.size()), 32'(total));
        n = (wq.size() < total) ? wq.size() : total;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s addr[%0d]", nm, k), 32'(wq[k].a), 32'(exp_addr(ib, fb, k)));
            chk($sformatf("%s data[%0d]", nm, k), 32'(wq[k].d), 32'(words[k]));
        end
        if (wq.size() > 0) chk({nm, " last_write_cycle"}, wq[wq.size()-1].c, 32'(last_hs + 1));

        repeat (10) @(negedge clk);
        conv_done = 1'b1;
        @(negedge clk);
        conv_done = 1'b0;
        chk({nm, " done_pulse"}, 32'(done), 1);
        chk({nm, " busy_in_finish"}, 32'(busy), 1);
        @(negedge clk);
        chk({nm, " done_one_cycle"}, 32'(done), 0);
        chk({nm, " idle_busy"}, 32'(busy), 0);
        chk({nm, " single_start"}, 32'(csq.size()), 1);
    endtask

    initial begin
        rst         = 1'b1;
        load_start  = 1'b0;
        img_base    = '0;
        flt_base    = '0;
        num_filters = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        conv_done   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst mem_wr_en", 32'(mem_wr_en), 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst mem_wdata", 32'(mem_wdata), 0);
        chk("rst conv_start", 32'(conv_start), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        run_load("basic", 8'h00, 8'h20, 2, 1'b1, 1'b0, 1'b0);
        // back-to-back: starts in the first IDLE cycle after FINISH
        run_load("nf0", 8'h10, 8'h80, 0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++)
            run_load($sformatf("stall%0d", r), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(1, 5)),
                     1'b0, 1'b1, 1'b0);
        run_load("wrap", 8'hF8, 8'hFE, 1, 1'b0, 1'b0, 1'b0);
        run_load("ignored", 8'h30, 8'h60, 2, 1'b0, 1'b0, 1'b1);

        // reset in the middle of the image
        load_start  = 1'b1;
        img_base    = 8'h40;
        flt_base    = 8'h50;
        num_filters = 8'd1;
        @(negedge clk);
        load_start = 1'b0;
        in_valid   = 1'b1;
        in_data    = 8'hA5;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst in_ready", 32'(in_ready), 0);
        chk("midrst mem_wr_en", 32'(mem_wr_en), 0);
        chk("midrst mem_addr", 32'(mem_addr), 0);
        chk("midrst mem_wdata", 32'(mem_wdata), 0);
        chk("midrst conv_start", 32'(conv_start), 0);
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(done), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_load("after_rst", 8'h40, 8'h50, 1, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
